cic_interp_var: RTL and testbench
=================================

# cic_interp_var

CIC interpolator, transmit-side counterpart of the variable-rate CIC decimators in the receive chain. Upsamples a slow sample stream by a fixed or run-time 2**k factor (1–2048) with STAGES comb/integrator stages and differential delay 1. It normalises gain with a variable arithmetic right shift, so passband gain is unity at every rate. It sits between a baseband source (demand-driven through `in_req`) and a faster consumer that paces the block with `out_ce`.

## Interface
- `STAGES`, 3: comb and integrator stage count N.
- `INTERPOLATION`, -2048: >0 fixed rate R (power of two, ≤2048), `interpolation` port ignored. <0 variable, with |value| = max R.
- `IN_WIDTH`, 16: input sample width, signed.
- `OUT_WIDTH`, 16: output sample width, signed, ≤IN_WIDTH.
- `GROWTH`, 22: accumulator growth bits. Must be ≥(STAGES-1)·log2(Rmax). ACC_WIDTH = IN_WIDTH+GROWTH.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `interpolation` in 14: run-time R, variable mode only. Legal values are 1,2,4,…,2048.
- `out_ce` in 1: output-rate enable, one pulse per output sample. Minimum spacing 2 clocks.
- `in_data` in IN_WIDTH: signed input sample, held stable by source between `in_req` pulses.
- `in_req` out 1: one-clock pulse; source must present the next sample before the next phase-0 `out_ce`.
- `out_data` out OUT_WIDTH: signed output sample.
- `out_valid` out 1: one-clock pulse when `out_data` updates.

## Operation
- Phase counter p, 0..R-1, advances on every `out_ce` and wraps R-1→0.
- **Phase-0 `out_ce`:**
  - `in_data` passes through N cascaded combs, each y = x − x_prev, with x_prev registers updated.
  - Result is registered in zero-stuff register zs.
  - `in_req` pulses on the next clock.
- **Other phases:** zs <= 0 on `out_ce`.
- **Integrators, every `out_ce`:** I1 <= I1+zs, Ik <= Ik+I(k-1) (old values), k=2..N.
- **Arithmetic:**
  - All comb and integrator registers are ACC_WIDTH two's complement and wrap modulo 2**ACC_WIDTH. Wrap is legal; the final result is exact while GROWTH holds.
  - Input is sign-extended into ACC_WIDTH.
- **Normalisation:**
  - s = (N-1)·log2(R); gain R^(N-1) is removed.
  - out = (IN >>> s), with bits [IN_WIDTH-1 -: OUT_WIDTH] taken.
- **Rate change:**
  - Any change of `interpolation` is detected on the clock it changes.
  - Combs, integrators, zs and p clear synchronously. `out_data` is held.
  - Operation restarts at phase 0 on the next `out_ce`.
- **Illegal `interpolation`** (0, non-power-of-two, >|INTERPOLATION|):
  - Block is held cleared: no `in_req`, no `out_valid`.
  - `out_data` is forced to 0.
- **Reset (`reset_n` low):** asynchronous, takes effect at any point mid-operation.
  - `out_data`=0, `out_valid`=0, `in_req`=0; all pipeline state and p = 0.
  - After deassertion, the first `out_ce` is phase 0.

## Timing
- `out_valid` and `out_data` update exactly 1 clock after each `out_ce`, in every phase.
- An input sampled at phase-0 `out_ce` #0 first affects `out_data` after `out_ce` #N (zs at #0, I1 at #1, IN at #N), i.e. 1 clock after `out_ce` #N.
- `in_req` is asserted 1 clock after each phase-0 `out_ce`. For R=1, `in_req` follows every `out_ce`.
- `out_ce` on the same clock as a rate change is ignored; the clear wins.
- No back-pressure: if the source misses a request, the stale `in_data` is used.

## Configuration
- `CIC_INTERP_ROUND_EN` defined:
  - 2**(s-1) is added to IN before the shift (round half up), with no rounding when s=0.
  - The shifted value saturates to the OUT_WIDTH signed range.
- `CIC_INTERP_ROUND_EN` undefined: plain truncating arithmetic shift, no saturation logic.

## Test plan
- **Reset:** assert `reset_n` low mid-stream with R=8.
  - `out_data`=0 and `out_valid`=0 immediately, without waiting for a clock edge.
  - After release, the first `in_req` follows the first `out_ce`.
- **Impulse, N=3, R=2:** input 4 then zeros.
  - After the N-sample latency, successive outputs are 1,3,3,1, then 0.
- **DC unity gain, N=3, R=4:** constant input 1000.
  - Output settles to exactly 1000 on every `out_ce`.
  - `in_req` occurs once per 4 `out_ce`.
- **Rate change:** switch `interpolation` from 4 to 2048 mid-stream.
  - State clears; DC input -12345 settles to -12345.
  - `in_req` occurs every 2048 `out_ce`.
- **Illegal rate:** `interpolation`=6.
  - No `in_req` or `out_valid` for 100 `out_ce`; `out_data`=0.
  - Recovers on `interpolation`=8.
- **Rounding:** with `CIC_INTERP_ROUND_EN`, R=2, N=2, impulse 3.
  - Outputs are 2,3,2; truncating build gives 1,3,1.

Source files
------------

// File: rtl/cic_interp_var.sv
// CIC interpolator: N combs at the input rate, zero-stuffing, N integrators at the out_ce rate,
// then a per-rate arithmetic right shift for unity gain. Optional macro: CIC_INTERP_ROUND_EN.
module cic_interp_var #(
  parameter int STAGES        = 3,
  parameter int INTERPOLATION = -2048,
  parameter int IN_WIDTH      = 16,
  parameter int OUT_WIDTH     = 16,
  parameter int GROWTH        = 22
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [13:0]          interpolation,
  input  logic                 out_ce,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_req,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid
);
  localparam int ACC_WIDTH = IN_WIDTH + GROWTH;
  localparam int RATE_MAX = (INTERPOLATION > 0) ? INTERPOLATION : -INTERPOLATION;
  localparam int PHASE_W = (RATE_MAX > 1) ? $clog2(RATE_MAX) : 1;
  localparam bit FIXED_RATE = (INTERPOLATION > 0);
  localparam logic [13:0] RATE_FIXED = 14'(RATE_MAX);
  localparam logic [14:0] RATE_LIMIT = 15'(RATE_MAX);

  logic [13:0]                      rate;
  logic [13:0]                      rate_prev_reg;
  logic                             rate_seen_reg;
  logic                             rate_legal;
  logic                             rate_change;
  logic                             clear;
  logic                             step;
  logic                             load;
  logic                             phase_last;
  logic [3:0]                       rate_log2;
  logic [7:0]                       shift;
  logic [PHASE_W-1:0]               phase_reg;
  logic [ACC_WIDTH-1:0]             zs_reg;
  logic [STAGES:0][ACC_WIDTH-1:0]   comb_x;
  logic [STAGES-1:0][ACC_WIDTH-1:0] integ_q;
  logic [STAGES-1:0][ACC_WIDTH-1:0] integ_next;
  logic signed [ACC_WIDTH-1:0]      shifted;
  logic [OUT_WIDTH-1:0]             norm;
  logic                             norm_unused;

  assign rate = FIXED_RATE ? RATE_FIXED : interpolation;

  always_comb begin
    rate_log2 = '0;
    for (int i = 0; i < 14; i++)
      if (rate[i]) rate_log2 = 4'(i);
  end

  assign rate_legal  = (rate != '0) && ((rate & (rate - 14'd1)) == '0) && ({1'b0, rate} <= RATE_LIMIT);
  assign shift       = 8'(STAGES - 1) * {4'b0, rate_log2};
  // rate_seen_reg keeps the first clock after reset from looking like a rate change
  assign rate_change = !FIXED_RATE && rate_seen_reg && (interpolation != rate_prev_reg);
  assign clear       = rate_change || !rate_legal;
  assign step        = out_ce && !clear;
  assign load        = step && (phase_reg == '0);
  assign phase_last  = ({{(14-PHASE_W){1'b0}}, phase_reg} == rate - 14'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rate_prev_reg <= '0;
      rate_seen_reg <= 1'b0;
    end else begin
      rate_prev_reg <= interpolation;
      rate_seen_reg <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_reg <= '0;
      zs_reg    <= '0;
    end else if (clear) begin
      phase_reg <= '0;
      zs_reg    <= '0;
    end else if (step) begin
      phase_reg <= phase_last ? '0 : phase_reg + PHASE_W'(1);
      zs_reg    <= load ? comb_x[STAGES] : '0;
    end
  end

  assign comb_x[0] = {{GROWTH{in_data[IN_WIDTH-1]}}, in_data};

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_comb
      logic [ACC_WIDTH-1:0] prev_reg;
      assign comb_x[gi+1] = comb_x[gi] - prev_reg;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   prev_reg <= '0;
        else if (clear) prev_reg <= '0;
        else if (load)  prev_reg <= comb_x[gi];
      end
    end

    // Each integrator adds the previous stage's old value, so the chain is a pure delay line of sums
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_integ
      logic [ACC_WIDTH-1:0] acc_reg;
      logic [ACC_WIDTH-1:0] feed;
      if (gi == 0) begin : g_first
        assign feed = zs_reg;
      end else begin : g_chain
        assign feed = integ_q[gi-1];
      end
      assign integ_q[gi]    = acc_reg;
      assign integ_next[gi] = acc_reg + feed;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   acc_reg <= '0;
        else if (clear) acc_reg <= '0;
        else if (step)  acc_reg <= integ_next[gi];
      end
    end
  endgenerate

`ifdef CIC_INTERP_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-IN_WIDTH+1){1'b0}}, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-IN_WIDTH+1){1'b1}}, {(IN_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH-1:0] rounded;
  logic signed [ACC_WIDTH-1:0] scaled;

  // Saturating to the IN_WIDTH range saturates the OUT_WIDTH field taken from its top bits
  always_comb begin
    rounded = $signed(integ_next[STAGES-1]);
    if (shift != 8'd0)
      rounded = rounded + $signed(ACC_WIDTH'(1) << (shift - 8'd1));
    scaled = rounded >>> shift;
    if ((~|scaled[ACC_WIDTH-1:IN_WIDTH-1]) || (&scaled[ACC_WIDTH-1:IN_WIDTH-1]))
      shifted = scaled;
    else
      shifted = scaled[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
  end
`else
  assign shifted = $signed(integ_next[STAGES-1]) >>> shift;
`endif

  assign norm        = shifted[IN_WIDTH-1 -: OUT_WIDTH];
  assign norm_unused = ^shifted;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      in_req    <= 1'b0;
    end else begin
      out_valid <= step;
      in_req    <= load;
      if (!rate_legal) out_data <= '0;
      else if (step)   out_data <= norm;
    end
  end
endmodule

// File: tb/tb_cic_interp_var.sv
// Scoreboard bench for cic_interp_var: the driver predicts each output by convolving the input
// samples with the CIC impulse response (box of length R convolved N times); a monitor compares.
`timescale 1ns/1ps
module tb_cic_interp_var;
  localparam int N  = 3;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int RMAX = 2048;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [13:0]   interpolation = 14'd8;
  logic          out_ce = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_req;
  logic [OW-1:0] out_data;
  logic          out_valid;

  cic_interp_var #(
    .STAGES(N), .INTERPOLATION(-RMAX), .IN_WIDTH(IW), .OUT_WIDTH(OW), .GROWTH(22)
  ) dut (
    .clock(clock), .reset_n(reset_n), .interpolation(interpolation), .out_ce(out_ce),
    .in_data(in_data), .in_req(in_req), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clock = ~clock;

  typedef struct { logic [OW-1:0] data; bit req; int idx; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int     rate_m;
  bit     legal_m;
  int     s_m;
  int     ce_idx;
  longint h[];
  longint xs[$];
  int     src_mode;   // 0 constant, 1 random, 2 zeros
  int     src_dc;

  task automatic model_restart(input int r);
    longint g[];
    longint acc;
    int old_n;
    int lg;
    rate_m = r;
    ce_idx = 0;
    xs.delete();
    legal_m = (r > 0) && ((r & (r - 1)) == 0) && (r <= RMAX);
    if (legal_m) begin
      lg = 0;
      while ((1 << lg) < r) lg++;
      s_m = (N - 1) * lg;
      h = new[1];
      h[0] = 1;
      for (int st = 0; st < N; st++) begin
        old_n = h.size();
        g = new[old_n + r - 1];
        acc = 0;
        for (int i = 0; i < g.size(); i++) begin
          if (i < old_n) acc += h[i];
          if (i - r >= 0 && i - r < old_n) acc -= h[i - r];
          g[i] = acc;
        end
        h = g;
      end
    end
  endtask

  function automatic longint model_y(input int j);
    longint y;
    int d;
    y = 0;
    for (int m = 0; m < xs.size(); m++) begin
      d = j - N - m * rate_m;
      if (d >= 0 && d < h.size()) y += xs[m] * h[d];
    end
    return y;
  endfunction

  function automatic logic [OW-1:0] model_out(input longint y);
    longint q;
    logic [63:0] qb;
`ifdef CIC_INTERP_ROUND_EN
    if (s_m > 0) y = y + (longint'(1) <<< (s_m - 1));
    q = y >>> s_m;
    if (q > (longint'(1) <<< (IW - 1)) - 1) q = (longint'(1) <<< (IW - 1)) - 1;
    if (q < -(longint'(1) <<< (IW - 1)))    q = -(longint'(1) <<< (IW - 1));
`else
    q = y >>> s_m;
`endif
    qb = q;
    return qb[IW-1 -: OW];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic next_sample();
    case (src_mode)
      0:       in_data = IW'(src_dc);
      1:       in_data = IW'($urandom);
      default: in_data = '0;
    endcase
  endtask

  task automatic issue_ce(input int gap);
    exp_t e;
    bit phase0;
    phase0 = 1'b0;
    out_ce = 1'b1;
    if (legal_m) begin
      phase0 = (ce_idx % rate_m) == 0;
      if (phase0) xs.push_back(longint'($signed(in_data)));
      e.data = model_out(model_y(ce_idx));
      e.req  = phase0;
      e.idx  = ce_idx;
      exp_q.push_back(e);
      ce_idx++;
    end
    tick();
    out_ce = 1'b0;
    if (phase0) next_sample();
    for (int i = 1; i < gap; i++) tick();
  endtask

  task automatic run(input int n, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) issue_ce(int'($urandom_range(gmax, gmin)));
  endtask

  task automatic change_rate(input int r);
    interpolation = 14'(r);
    model_restart(r);
    tick();
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d required=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_val(input string name, input longint got, input longint req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid got=1 required=0 data=%0d", $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          $display("txn idx=%0d rate=%0d out_data=%0d exp=%0d in_req=%0b", e.idx, rate_m,
                   $signed(out_data), $signed(e.data), in_req);
          checks++;
          if (out_data !== e.data) begin
            errors++;
            $display("FAIL out_data idx=%0d got=%0d required=%0d", e.idx, $signed(out_data), $signed(e.data));
          end
          checks++;
          if (in_req !== e.req) begin
            errors++;
            $display("FAIL in_req idx=%0d got=%0b required=%0b", e.idx, in_req, e.req);
          end
        end
      end else if (in_req) begin
        errors++;
        $display("FAIL stray_in_req got=1 required=0");
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge
    #1 reset_n = 1'b0;
    #1;
    check_val("reset_out_data", longint'(out_data), 0);
    check_val("reset_out_valid", longint'(out_valid), 0);
    check_val("reset_in_req", longint'(in_req), 0);
    tick(); tick();
    reset_n = 1'b1;
    model_restart(8);
    src_mode = 0; src_dc = 1000; in_data = IW'(src_dc);
    run(40, 2, 4);
    check_drained("drain_r8_dc");

    // Reset mid-stream at R=8: outputs drop without a clock edge
    out_ce = 1'b1;
    tick();
    out_ce = 1'b0;
    #1;
    check_val("pre_reset_valid", longint'(out_valid), 1);
    check_val("pre_reset_data", longint'($signed(out_data)), 1000);
    reset_n = 1'b0;
    #1;
    check_val("async_reset_data", longint'(out_data), 0);
    check_val("async_reset_valid", longint'(out_valid), 0);
    exp_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    model_restart(8);
    run(24, 2, 4);
    check_drained("drain_after_reset");

    // Impulse at R=2: 4 then zeros gives 1,3,3,1
    src_mode = 2; in_data = IW'(4);
    change_rate(2);
    run(14, 2, 3);
    check_drained("drain_impulse");

    // Random data at a spread of rates
    src_mode = 1; in_data = IW'($urandom);
    change_rate(16);  run(80, 2, 4);
    change_rate(1);   run(60, 2, 4);
    change_rate(32);  run(120, 2, 3);
    check_drained("drain_random");

    // DC at R=4; the out_ce coinciding with the rate change is discarded
    src_mode = 0; src_dc = 1000; in_data = IW'(src_dc);
    interpolation = 14'd4;
    model_restart(4);
    out_ce = 1'b1;
    tick();
    out_ce = 1'b0;
    tick();
    run(40, 2, 4);
    check_drained("drain_r4_dc");

    // Switch to R=2048 mid-stream with DC -12345
    src_dc = -12345; in_data = IW'(src_dc);
    change_rate(2048);
    run(3 * 2048 + 40, 2, 2);
    check_val("r2048_settled", longint'($signed(out_data)), -12345);
    check_drained("drain_r2048");

    // Illegal rates hold the block cleared
    src_mode = 1;
    change_rate(6);
    for (int i = 0; i < 100; i++) begin
      issue_ce(2);
      check_val("illegal6_out_data", longint'(out_data), 0);
    end
    change_rate(0);
    run(10, 2, 3);
    check_val("illegal0_out_data", longint'(out_data), 0);
    change_rate(4096);
    run(10, 2, 3);
    check_val("illegal4096_out_data", longint'(out_data), 0);
    check_drained("drain_illegal");

    // Recovery at R=8
    change_rate(8);
    run(40, 2, 4);
    check_drained("drain_recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
